// File: rtl/pe_cfg_pkg.sv
// Shared frame layout, limits and decoder state encoding for the PE config path.
// No logic beyond a pure helper that rebuilds a frame from committed fields.
package pe_cfg_pkg;

    localparam int FRAME_W = 16;
    localparam logic [3:0] SYNC_WORD = 4'b1010;

    localparam int SYNC_HI      = 15;
    localparam int SYNC_LO      = 12;
    localparam int ALU_HI       = 11;
    localparam int ALU_LO       = 9;
    localparam int TIDE_EN_POS  = 8;
    localparam int TIDE_RST_POS = 7;
    localparam int RSV_HI       = 6;
    localparam int RSV_LO       = 1;
    localparam int PAR_POS      = 0;

    localparam logic [2:0] ALU_FUNC_MAX = 3'd6;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SHIFT,
        ST_CHECK
    } state_t;

    // Frame with sync header, zero reserved bits and even parity over all 16 bits.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [2:0] alu,
                                                       input logic       en,
                                                       input logic       rs);
        logic [FRAME_W-1:0] f;
        f                       = '0;
        f[SYNC_HI:SYNC_LO]      = SYNC_WORD;
        f[ALU_HI:ALU_LO]        = alu;
        f[TIDE_EN_POS]          = en;
        f[TIDE_RST_POS]         = rs;
        f[PAR_POS]              = ^f[FRAME_W-1:1];
        return f;
    endfunction

endpackage

// File: rtl/pe_cfg_readback.sv
// Snapshots the committed config as a 16-bit frame and streams it out MSB first.
// Latency: first bit valid the cycle after rb_req is taken; no backpressure, requests while busy are dropped.
module pe_cfg_readback
    import pe_cfg_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rb_req,
    input  logic [2:0] i_alu_func,
    input  logic       i_tide_en,
    input  logic       i_tide_rst,
    output logic       o_rb_bit,
    output logic       o_rb_valid
);

    logic [FRAME_W-1:0] w_frame;
    logic [FRAME_W-1:0] r_sr;
    logic [3:0]         r_left;
    logic               r_valid;
    logic               r_bit;

    assign w_frame = build_frame(i_alu_func, i_tide_en, i_tide_rst);

    // r_left counts bits still to present after the current one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_bit   <= 1'b0;
            r_sr    <= '0;
            r_left  <= 4'd0;
        end else if (!r_valid) begin
            if (i_rb_req) begin
                r_valid <= 1'b1;
                r_bit   <= w_frame[FRAME_W-1];
                r_sr    <= {w_frame[FRAME_W-2:0], 1'b0};
                r_left  <= 4'd15;
            end
        end else if (r_left != 4'd0) begin
            r_bit  <= r_sr[FRAME_W-1];
            r_sr   <= {r_sr[FRAME_W-2:0], 1'b0};
            r_left <= r_left - 4'd1;
        end else begin
            r_valid <= 1'b0;
            r_bit   <= 1'b0;
        end
    end

    assign o_rb_valid = r_valid;
    assign o_rb_bit   = r_bit;

endmodule

// File: rtl/pe_cfg_decoder.sv
// Serial config frame hunter/decoder with commit-on-check and independent readback.
// Latency: commit visible 2 cycles after the 16th bit; backpressure: cfg_ready low for the one CHECK cycle.
module pe_cfg_decoder
    import pe_cfg_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cfg_bit,
    input  logic       i_cfg_valid,
    output logic       o_cfg_ready,
    output logic [2:0] o_alu_func,
    output logic       o_tide_en,
    output logic       o_tide_rst,
    output logic       o_cfg_done,
    output logic       o_cfg_err,
    output logic       o_cfg_locked,
    input  logic       i_rb_req,
    output logic       o_rb_bit,
    output logic       o_rb_valid
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FRAME_W-1:0] r_frame;
    logic [3:0]         r_cnt;
    logic [2:0]         r_alu_func;
    logic               r_tide_en;
    logic               r_tide_rst;
    logic               r_done;
    logic               r_err;
    logic               r_locked;

    logic               w_accept;
    logic [FRAME_W-1:0] w_shifted;
    logic               w_pass;

    assign o_cfg_ready = (r_state != ST_CHECK) && !i_rst;
    assign w_accept    = i_cfg_valid && o_cfg_ready;
    assign w_shifted   = {r_frame[FRAME_W-2:0], i_cfg_bit};
    assign w_pass      = ((^r_frame) == 1'b0)
                      && (r_frame[RSV_HI:RSV_LO] == '0)
                      && (r_frame[ALU_HI:ALU_LO] <= ALU_FUNC_MAX);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HUNT:  if (w_accept && w_shifted[3:0] == SYNC_WORD) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_accept && r_cnt == 4'd15)              w_state_nxt = ST_CHECK;
            ST_CHECK: w_state_nxt = ST_HUNT;
            default:  w_state_nxt = ST_HUNT;
        endcase
    end

    // The low nibble of r_frame doubles as the sync window while hunting.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_HUNT;
            r_frame    <= '0;
            r_cnt      <= 4'd0;
            r_alu_func <= 3'd0;
            r_tide_en  <= 1'b0;
            r_tide_rst <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_HUNT: if (w_accept) begin
                    r_frame <= w_shifted;
                    r_cnt   <= 4'd4;
                end
                ST_SHIFT: if (w_accept) begin
                    r_frame <= w_shifted;
                    r_cnt   <= r_cnt + 4'd1;
                end
                ST_CHECK: begin
                    if (w_pass) begin
                        r_alu_func <= r_frame[ALU_HI:ALU_LO];
                        r_tide_en  <= r_frame[TIDE_EN_POS];
                        r_tide_rst <= r_frame[TIDE_RST_POS];
                        r_done     <= 1'b1;
                        r_locked   <= 1'b1;
                    end else begin
                        r_err      <= 1'b1;
                    end
                    r_frame <= '0;
                    r_cnt   <= 4'd0;
                end
                default: begin
                    r_frame <= '0;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign o_alu_func   = r_alu_func;
    assign o_tide_en    = r_tide_en;
    assign o_tide_rst   = r_tide_rst;
    assign o_cfg_done   = r_done;
    assign o_cfg_err    = r_err;
    assign o_cfg_locked = r_locked;

    pe_cfg_readback u_readback (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rb_req   (i_rb_req),
        .i_alu_func (r_alu_func),
        .i_tide_en  (r_tide_en),
        .i_tide_rst (r_tide_rst),
        .o_rb_bit   (o_rb_bit),
        .o_rb_valid (o_rb_valid)
    );

endmodule

// File: doc/pe_cfg_decoder.md
PE_CFG_DECODER -- requirements
Module: pe_cfg_decoder

Interface
REQ-001 SYNC_WORD, 4'b1010, frame header the hunter matches.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 cfg_bit  in  1  serial config bit, MSB of frame first.
REQ-005 cfg_valid  in  1  cfg_bit valid this cycle.
REQ-006 cfg_ready  out  1  block can accept a bit; a bit is accepted when cfg_valid and cfg_ready are both high.
REQ-007 alu_func  out  3  committed ALU function select, legal range 0..6.
REQ-008 tide_en  out  1  committed enable-tie control for the reg_unit.
REQ-009 tide_rst  out  1  committed reset-tie control for the reg_unit.
REQ-010 cfg_done  out  1  one-cycle pulse when a frame commits.
REQ-011 cfg_err  out  1  one-cycle pulse when a frame is rejected.
REQ-012 cfg_locked  out  1  high after the first successful commit.
REQ-013 rb_req  in  1  request serial readback of the committed config.
REQ-014 rb_bit  out  1  readback data bit, MSB first.
REQ-015 rb_valid  out  1  rb_bit is valid this cycle.

Function
REQ-016 Frame is 16 bits: [15:12] sync, [11:9] alu_func, [8] tide_en, [7] tide_rst, [6:1] reserved, [0] parity making the whole frame even.
REQ-017 FSM states: HUNT, SHIFT, CHECK.
- HUNT: every accepted bit shifts into a 4-bit window.
- When the window equals SYNC_WORD, go to SHIFT with the bit count at 4.
REQ-018 SHIFT: accept 12 further bits; the edge that accepts bit 16 moves the FSM to CHECK.
REQ-019 cfg_ready is 1 in HUNT and SHIFT and 0 in CHECK; cfg_bit is ignored when cfg_ready is 0.
REQ-020 CHECK lasts exactly one cycle. The frame passes only if all three hold:
- even parity;
- reserved bits all zero;
- alu_func not 7.
REQ-021 On pass, at the edge ending CHECK:
- alu_func, tide_en and tide_rst update;
- cfg_done is 1 for the following cycle;
- cfg_locked sets;
- FSM returns to HUNT.
REQ-022 On fail, at the edge ending CHECK:
- outputs are held;
- cfg_err is 1 for the following cycle;
- FSM returns to HUNT.
REQ-023 The sync window clears on entry to HUNT, so a new frame is matched only from bits accepted after CHECK.
REQ-024 cfg_valid gaps in SHIFT stall the counter with no timeout; a partial frame is kept indefinitely.
REQ-025 rb_req is accepted only while readback is idle.
- The committed fields, with parity recomputed, are snapshotted into a 16-bit frame.
- rb_valid is high for exactly 16 cycles, starting the cycle after the accepting edge; rb_bit carries the frame MSB first.
REQ-026 rb_req while readback is busy is ignored. A commit during readback does not alter the in-flight snapshot.
REQ-027 Readback and frame decode operate concurrently and independently.

Reset
REQ-028 While rst is high, at each edge the block enters the reset state:
- FSM to HUNT; window, counter and shift register cleared;
- readback goes idle;
- alu_func=0, tide_en=0, tide_rst=0;
- cfg_done=0, cfg_err=0, cfg_locked=0, rb_valid=0, rb_bit=0.
REQ-029 cfg_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
REQ-030 Reset mid-frame or mid-readback discards the partial frame or stream; no done/err pulse occurs.

Structure
REQ-031 Shared package pe_cfg_pkg holds:
- FRAME_W=16;
- field bit positions;
- ALU_FUNC_MAX=6;
- the FSM state enum.
REQ-032 Sub-module pe_cfg_readback implements the snapshot and serializer of REQ-025/026.

Verification
REQ-033 After reset, send 0xAB01 continuously:
- alu_func=5, tide_en=1, tide_rst=0;
- cfg_done pulses once, cfg_locked=1;
- cfg_ready=0 for exactly one cycle.
REQ-034 Send 0xAE01 (alu_func=7):
- cfg_err pulses once;
- outputs keep their prior values; cfg_done stays 0.
REQ-035 Send 0xAB00 (parity error) -> cfg_err pulses; outputs unchanged.
REQ-036 Send bits 1,1 then 0xAB01, with random cfg_valid gaps -> decodes to alu_func=5, tide_en=1.
REQ-037 Send 8 bits of 0xAB01, pulse rst, then send 0xA201:
- alu_func=1, tide_en=0, tide_rst=0;
- exactly one cfg_done.
REQ-038 After committing 0xAB01, pulse rb_req:
- 16 rb_valid cycles carry 0xAB01 MSB first;
- a second rb_req mid-stream is ignored;
- committing 0xA201 mid-stream does not alter the stream.
